// File: rtl/prio_arbiter4_if.sv
// rtl/prio_arbiter4_if.sv - request/grant bundle between clients and prio_arbiter4
interface prio_arbiter4_if;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       busy;

    // Client side: raises requests, observes the grant.
    modport master (
        output req,
        input  gnt,
        input  gnt_id,
        input  gnt_valid,
        input  busy
    );

    // Arbiter side: samples requests, drives the registered grant.
    modport slave (
        input  req,
        output gnt,
        output gnt_id,
        output gnt_valid,
        output busy
    );
endinterface

// File: rtl/prio_arbiter4.sv
// rtl/prio_arbiter4.sv - 4-way registered arbiter with hold limit; PRIO_ARBITER4_ROUND_ROBIN_EN selects rotating priority
module prio_arbiter4 #(
    parameter int MAX_HOLD = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    prio_arbiter4_if.slave bus
);

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("prio_arbiter4: MAX_HOLD must be in 2..255");
    end

    // Last hold_cnt value of a grant; reaching it forces the release.
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t     state,       state_d;
    logic [3:0] gnt_q,       gnt_d;
    logic [1:0] gnt_id_q,    gnt_id_d;
    logic       gnt_valid_q, gnt_valid_d;
    logic       busy_q,      busy_d;
    logic [7:0] hold_cnt,    hold_cnt_d;
    logic [1:0] last_id,     last_id_d;
    logic [1:0] win_id;
    logic       release_now;

`ifdef PRIO_ARBITER4_ROUND_ROBIN_EN
    // Rotating priority: start just below the previous owner and walk down with wrap.
    // Scanning from lowest to highest priority lets the last hit be the winner.
    always_comb begin
        logic [1:0] cand;
        cand   = 2'd0;
        win_id = last_id - 2'd1;
        for (int k = 3; k >= 0; k--) begin
            cand = last_id - 2'd1 - 2'(k);
            if (bus.req[cand]) begin
                win_id = cand;
            end
        end
    end
`else
    // Fixed priority: highest set request bit wins.
    always_comb begin
        win_id = 2'd0;
        if (bus.req[3]) begin
            win_id = 2'd3;
        end else if (bus.req[2]) begin
            win_id = 2'd2;
        end else if (bus.req[1]) begin
            win_id = 2'd1;
        end else begin
            win_id = 2'd0;
        end
    end

    // last_id only steers rotation; in fixed mode it is kept for visibility only.
    logic unused_last_id;
    assign unused_last_id = ^last_id;
`endif

    // Owner gives up the resource when it drops its request or hits the hold limit.
    assign release_now = !bus.req[gnt_id_q] || (hold_cnt == HOLD_LAST);

    // Next-state and next-output decode for the IDLE -> GRANT -> RELEASE cycle.
    always_comb begin
        state_d     = state;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
        busy_d      = busy_q;
        hold_cnt_d  = hold_cnt;
        last_id_d   = last_id;

        unique case (state)
            IDLE: begin
                if (|bus.req) begin
                    state_d     = GRANT;
                    gnt_d       = 4'b0001 << win_id;
                    gnt_id_d    = win_id;
                    gnt_valid_d = 1'b1;
                    busy_d      = 1'b1;
                    hold_cnt_d  = 8'd0;
                end else begin
                    gnt_d       = 4'b0000;
                    gnt_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end
            end
            GRANT: begin
                // Counter saturates so a long grant can never wrap past the limit.
                if (hold_cnt != HOLD_LAST) begin
                    hold_cnt_d = hold_cnt + 8'd1;
                end
                if (release_now) begin
                    state_d     = RELEASE;
                    gnt_d       = 4'b0000;
                    gnt_valid_d = 1'b0;
                    busy_d      = 1'b1;
                    last_id_d   = gnt_id_q;
                end
            end
            RELEASE: begin
                // Dead cycle separating two owners on the shared resource.
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d     = IDLE;
                gnt_d       = 4'b0000;
                gnt_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears everything including last_id.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            gnt_q       <= 4'b0000;
            gnt_id_q    <= 2'd0;
            gnt_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            hold_cnt    <= 8'd0;
            last_id     <= 2'd0;
        end else begin
            state       <= state_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            busy_q      <= busy_d;
            hold_cnt    <= hold_cnt_d;
            last_id     <= last_id_d;
        end
    end

    // Registered grant must be one-hot-or-zero and consistent with gnt_valid.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert ($onehot0(gnt_q));
            assert (gnt_valid_q == (|gnt_q));
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_id    = gnt_id_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_prio_arbiter4.sv
// tb/tb_prio_arbiter4.sv - vector table plus randomized model check for prio_arbiter4
module tb_prio_arbiter4;

    localparam int MH = 4;

`ifdef PRIO_ARBITER4_ROUND_ROBIN_EN
    localparam bit         RR     = 1'b1;
    localparam logic [3:0] FR_GNT = 4'b0001;
    localparam logic [1:0] FR_ID  = 2'd0;
`else
    localparam bit         RR     = 1'b0;
    localparam logic [3:0] FR_GNT = 4'b1000;
    localparam logic [1:0] FR_ID  = 2'd3;
`endif

    logic clk;
    logic rst_n;

    prio_arbiter4_if bus ();

    prio_arbiter4 #(.MAX_HOLD(MH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] id;
        logic       valid;
        logic       busy;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model in terms of ownership: who holds the resource, for how many
    // cycles, and how many dead cycles remain before the next arbitration.
    int m_owner = -1;
    int m_held  = 0;
    int m_cool  = 0;
    int m_last  = 0;
    int m_gid   = 0;

    function automatic void add(input logic r, input logic [3:0] q, input logic [3:0] g,
                                input logic [1:0] id, input logic v, input logic b);
        vec_t e;
        e.rst_n = r; e.req = q; e.gnt = g; e.id = id; e.valid = v; e.busy = b;
        vecs.push_back(e);
    endfunction

    function automatic int pick(input logic [3:0] q, input int last);
        int idx;
        for (int k = 0; k < 4; k++) begin
            idx = RR ? ((last + 3 - k) % 4) : (3 - k);
            if (q[idx]) return idx;
        end
        return 0;
    endfunction

    function automatic void model_update(input logic r, input logic [3:0] q);
        if (!r) begin
            m_owner = -1; m_held = 0; m_cool = 0; m_last = 0; m_gid = 0;
        end else if (m_owner >= 0) begin
            if (!q[m_owner] || m_held == MH) begin
                m_last  = m_owner;
                m_owner = -1;
                m_cool  = 1;
            end else begin
                m_held++;
            end
        end else if (m_cool > 0) begin
            m_cool--;
        end else if (q != 4'b0000) begin
            m_owner = pick(q, m_last);
            m_gid   = m_owner;
            m_held  = 1;
        end
    endfunction

    task automatic step(input logic r, input logic [3:0] q);
        rst_n   = r;
        bus.req = q;
        @(posedge clk);
        model_update(r, q);
        @(negedge clk);
    endtask

    task automatic compare(input string name, input int idx, input logic [3:0] g,
                           input logic [1:0] id, input logic v, input logic b);
        checks++;
        if ({bus.gnt, bus.gnt_id, bus.gnt_valid, bus.busy} !== {g, id, v, b}) begin
            errors++;
            $display("FAIL %s[%0d] got gnt=%b id=%0d valid=%b busy=%b expected gnt=%b id=%0d valid=%b busy=%b",
                     name, idx, bus.gnt, bus.gnt_id, bus.gnt_valid, bus.busy, g, id, v, b);
        end
    endtask

    initial begin
        logic [3:0] rq;
        logic       rr;
        logic [3:0] eg;

        rst_n   = 1'b0;
        bus.req = 4'b0000;
        @(negedge clk);

        // Reset held with all requests, then idle.
        add(0, 4'b1111, 4'b0000, 2'd0, 0, 0);
        add(0, 4'b1111, 4'b0000, 2'd0, 0, 0);
        add(0, 4'b1111, 4'b0000, 2'd0, 0, 0);
        add(1, 4'b0000, 4'b0000, 2'd0, 0, 0);
        add(1, 4'b0000, 4'b0000, 2'd0, 0, 0);
        // Priority resolve 0110 -> id 2, release, idle.
        add(1, 4'b0110, 4'b0100, 2'd2, 1, 1);
        add(1, 4'b0110, 4'b0100, 2'd2, 1, 1);
        add(1, 4'b0000, 4'b0000, 2'd2, 0, 1);
        add(1, 4'b0000, 4'b0000, 2'd2, 0, 0);
        add(1, 4'b0000, 4'b0000, 2'd2, 0, 0);
        // No preemption: id 1 keeps the grant while req[3] rises.
        add(1, 4'b0010, 4'b0010, 2'd1, 1, 1);
        add(1, 4'b1010, 4'b0010, 2'd1, 1, 1);
        add(1, 4'b1010, 4'b0010, 2'd1, 1, 1);
        add(1, 4'b1000, 4'b0000, 2'd1, 0, 1);
        add(1, 4'b1000, 4'b0000, 2'd1, 0, 0);
        add(1, 4'b1000, 4'b1000, 2'd3, 1, 1);
        add(1, 4'b0000, 4'b0000, 2'd3, 0, 1);
        add(1, 4'b0000, 4'b0000, 2'd3, 0, 0);
        // Forced release after MAX_HOLD cycles with 1001 held.
        add(0, 4'b0000, 4'b0000, 2'd0, 0, 0);
        for (int i = 0; i < MH; i++) add(1, 4'b1001, 4'b1000, 2'd3, 1, 1);
        add(1, 4'b1001, 4'b0000, 2'd3, 0, 1);
        add(1, 4'b1001, 4'b0000, 2'd3, 0, 0);
        add(1, 4'b1001, FR_GNT, FR_ID, 1, 1);
        // Reset mid-grant at hold_cnt 2, then a full-length grant.
        add(0, 4'b0000, 4'b0000, 2'd0, 0, 0);
        add(1, 4'b0100, 4'b0100, 2'd2, 1, 1);
        add(1, 4'b0100, 4'b0100, 2'd2, 1, 1);
        add(1, 4'b0100, 4'b0100, 2'd2, 1, 1);
        add(0, 4'b0100, 4'b0000, 2'd0, 0, 0);
        for (int i = 0; i < MH; i++) add(1, 4'b0100, 4'b0100, 2'd2, 1, 1);
        add(1, 4'b0100, 4'b0000, 2'd2, 0, 1);
        add(1, 4'b0000, 4'b0000, 2'd2, 0, 0);
        // Rotation 3,2,1,0,3 with each owner dropping after one cycle.
        add(0, 4'b0000, 4'b0000, 2'd0, 0, 0);
        add(1, 4'b1111, 4'b1000, 2'd3, 1, 1);
        add(1, 4'b0111, 4'b0000, 2'd3, 0, 1);
        add(1, 4'b0111, 4'b0000, 2'd3, 0, 0);
        add(1, 4'b0111, 4'b0100, 2'd2, 1, 1);
        add(1, 4'b0011, 4'b0000, 2'd2, 0, 1);
        add(1, 4'b0011, 4'b0000, 2'd2, 0, 0);
        add(1, 4'b0011, 4'b0010, 2'd1, 1, 1);
        add(1, 4'b0001, 4'b0000, 2'd1, 0, 1);
        add(1, 4'b0001, 4'b0000, 2'd1, 0, 0);
        add(1, 4'b0001, 4'b0001, 2'd0, 1, 1);
        add(1, 4'b1110, 4'b0000, 2'd0, 0, 1);
        add(1, 4'b1111, 4'b0000, 2'd0, 0, 0);
        add(1, 4'b1111, 4'b1000, 2'd3, 1, 1);
        add(1, 4'b0000, 4'b0000, 2'd3, 0, 1);
        add(1, 4'b0000, 4'b0000, 2'd3, 0, 0);

        foreach (vecs[i]) begin
            step(vecs[i].rst_n, vecs[i].req);
            compare("vec", i, vecs[i].gnt, vecs[i].id, vecs[i].valid, vecs[i].busy);
        end

        // Randomized traffic: requests persist for a while so forced releases occur.
        step(1'b0, 4'b0000);
        rq = 4'b0000;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
            rr = ($urandom_range(0, 149) != 0);
            step(rr, rq);
            eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
            compare("rand", i, eg, 2'(m_gid), (m_owner >= 0), (m_owner >= 0) || (m_cool > 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
